// File: rtl/add32_pkg.sv
// Shared constants and types for the add32_stream adder front/back end.
package add32_pkg;

  localparam int WIDTH      = 32;
  localparam int ACC_W      = 40;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } result_t;

  typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/bitmodifiedcarrygatelevel.sv
// Gate-level ripple adder: generate/propagate per bit, carry built from
// explicit AND/OR/XOR primitives.
module bitmodifiedcarrygatelevel #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  wire [WIDTH-1:0] w_p;
  wire [WIDTH-1:0] w_g;
  wire [WIDTH-1:0] w_pc;
  wire [WIDTH:0]   w_c;

  assign w_c[0] = 1'b0;

  // Modified carry: c[i+1] = g[i] | (p[i] & c[i]), sum reuses the propagate XOR.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor u_p   (w_p[i],    a[i],   b[i]);
    and u_g   (w_g[i],    a[i],   b[i]);
    and u_pc  (w_pc[i],   w_p[i], w_c[i]);
    or  u_c   (w_c[i+1],  w_g[i], w_pc[i]);
    xor u_s   (sum[i],    w_p[i], w_c[i]);
  end

  assign cout = w_c[WIDTH];

endmodule

// File: rtl/add32_stream.sv
// Stream wrapper around the gate-level adder: operand register stage, credit
// flow-controlled result FIFO, and a running accumulator of delivered results.
module add32_stream #(
  parameter int WIDTH      = add32_pkg::WIDTH,
  parameter int FIFO_DEPTH = add32_pkg::FIFO_DEPTH,
  parameter int ACC_W      = add32_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  input  logic             acc_clear,
  output logic [ACC_W-1:0] acc_total,
  output logic [15:0]      txn_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds data stable while valid=1 and ready=0, ready never looks
  // at valid on the same side, and in_ready is a function of registers only.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic [WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [ACC_W-1:0] r_acc;
  logic [15:0]      r_txn;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic [CNT_W:0]   w_used;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH:0]   w_head;
  logic [ACC_W-1:0] w_head_ext;

  bitmodifiedcarrygatelevel #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (r_s1_a),
    .b    (r_s1_b),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Credits cover both buffered entries and the one sitting in stage 1, so a
  // push can never find the FIFO full.
  assign w_used     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign in_ready   = (w_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_accept   = in_valid && in_ready;
  assign w_push     = r_s1_valid;
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;

  assign w_head     = r_mem[r_rd_ptr];
  assign out_sum    = out_valid ? w_head[WIDTH-1:0] : '0;
  assign out_cout   = out_valid ? w_head[WIDTH] : 1'b0;
  assign w_head_ext = {{(ACC_W-WIDTH-1){1'b0}}, w_head};

  assign acc_total  = r_acc;
  assign txn_count  = r_txn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a <= in_a;
        r_s1_b <= in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_cout, w_sum};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A clear that coincides with a pop restarts the totals from that pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_txn <= '0;
    end else if (acc_clear) begin
      r_acc <= w_pop ? w_head_ext : '0;
      r_txn <= w_pop ? 16'd1 : 16'd0;
    end else if (w_pop) begin
      r_acc <= r_acc + w_head_ext;
      r_txn <= r_txn + 16'd1;
    end
  end

endmodule

// File: doc/add32_stream.md
Name: add32_stream

Overview:
Sequential front/back end for the team's 32-bit gate-level modified-carry adder (bitmodifiedcarrygatelevel).
- Upstream side: accepts operand pairs over a valid/ready handshake and registers them into the adder.
- Downstream side: captures sum/cout into a small output FIFO for a valid/ready consumer.
- Keeps a running 40-bit accumulation and a transaction counter of delivered results.
- Sits between the operand source and any consumer of adder results.

Parameters:
- WIDTH, 32, operand/sum width; must match the adder instance.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- ACC_W, 40, accumulator width; must be greater than WIDTH+1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_sum  out  WIDTH  head sum.
- out_cout  out  1  head carry-out.
- acc_clear  in  1  synchronous clear of acc_total and txn_count.
- acc_total  out  ACC_W  running sum of {cout,sum} of popped results, modulo 2^ACC_W.
- txn_count  out  16  number of popped results, wraps at 2^16.

Interface (already decided): one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset: rst=1 at a rising edge clears the following.
  - s1_valid, FIFO pointers and count, acc_total, txn_count all go to 0.
  - out_valid=0; in_ready=1 in the cycle after reset.
  - out_sum/out_cout=0 while the FIFO is empty.
  - rst mid-operation discards all in-flight and buffered data; no partial pop is counted.
- Accept: an operand pair is accepted at an edge where in_valid && in_ready.
  - in_a/in_b are latched into stage-1 registers s1_a/s1_b, and s1_valid is set.
- Stage 1 to FIFO:
  - The adder is combinational from s1_a/s1_b.
  - When s1_valid=1, {cout,sum} is written to the FIFO tail at the next edge, then s1_valid clears unless a new accept occurs in the same cycle.
  - Throughput: 1 pair per cycle when unstalled.
- Latency: accept at edge N makes out_valid=1 after edge N+1, with FIFO empty and no backpressure. The pair is therefore visible in the cycle following edge N+1.
- Credit flow control:
  - in_ready = (fifo_count + s1_valid) < FIFO_DEPTH, combinational from registered state only.
  - It does not depend on out_ready, so there is no combinational in-to-out path.
  - The FIFO therefore never overflows; writes are never dropped.
- Pop: occurs at an edge where out_valid && out_ready; the head advances.
  - out_sum/out_cout always show the head entry; the head is held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: fifo_count is unchanged. With FIFO full, a pop in the same cycle does not raise in_ready until the next cycle (credit returns 1 cycle later).
- Empty and full: out_valid=0 when empty. Pointers wrap modulo FIFO_DEPTH.
- Accumulator:
  - On each pop, acc_total += zero-extended {out_cout,out_sum}, wrapping modulo 2^ACC_W.
  - On each pop, txn_count += 1, wrapping.
- acc_clear:
  - acc_clear=1 without a pop sets acc_total=0 and txn_count=0.
  - acc_clear=1 with a pop in the same edge sets acc_total={cout,sum} of that pop and txn_count=1.
  - rst has priority over acc_clear.
- Ignored inputs: in_a/in_b are ignored when in_valid=0 or in_ready=0. out_ready is ignored when out_valid=0.

Decomposition:
- Package add32_pkg holds:
  - constants WIDTH=32, ACC_W=40, FIFO_DEPTH=4;
  - typedef result_t as a packed struct {cout, sum[WIDTH-1:0]};
  - typedef acc_t as logic [ACC_W-1:0].
- Sub-module: one instance of bitmodifiedcarrygatelevel (ports a, b, sum, cout), unchanged.
- FIFO storage, stage-1 registers and the accumulator stay inline.

Test Plan:
1. Basic add: out_ready=1; push a=0x00000001, b=0x00000001 at edge N.
   - Required: out_valid=1 after edge N+1 with out_sum=0x00000002, out_cout=0.
   - After the pop: acc_total=0x2, txn_count=1.
2. Carry out: push 0xFFFF0006 + 0x12560006.
   - Required: out_sum=0x1255000C, out_cout=1.
   - After the pop: acc_total=0x011255000C.
3. Backpressure: out_ready=0, in_valid=1 held continuously.
   - Required: exactly 4 pairs accepted and in_ready=0 thereafter, with head stable.
   - Then raise out_ready: 4 results pop in order, and in_ready returns 1 cycle after the first pop.
4. Accumulator wrap and clear:
   - Push 0xFFFFFFFF + 0xFFFFFFFF twice and pop both. Required: acc_total=0x03FFFFFFFC, txn_count=2.
   - Then acc_clear concurrent with a pop of 0x00000010+0x66660010. Required: acc_total=0x0066660020, txn_count=1.
5. Back-to-back streaming: 10 consecutive pairs with out_ready=1.
   - Required: in_ready stays 1 and outputs arrive 1 per cycle in order, with correct sum/cout per pair (e.g. 0xDEDCFFFF+0xFEDCFFFF gives sum 0xDDB9FFFE, cout=1).
6. Reset mid-operation: rst for 1 cycle with 3 entries buffered and s1_valid=1.
   - Required: next cycle out_valid=0, in_ready=1, acc_total=0, txn_count=0.
   - A new push then completes normally.
